fp_add_arbiter: RTL
===================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter TAG_W, default 2, requester-index width, equal to clog2(NUM_REQ).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-007 req_a  input  32*NUM_REQ  IEEE-754 single operand A; requester i at bits [32i+31:32i].
REQ-008 req_b  input  32*NUM_REQ  IEEE-754 single operand B; same packing as req_a.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_data  output  32  sum a+b from the shared adder.
REQ-012 res_tag  output  TAG_W  index of the requester that issued the result.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 op_count  output  16  count of completed result handshakes.

Function
REQ-015 FSM states: IDLE, CALC, DONE; encoding from the shared package.
REQ-016 Request transfer on req_valid[i] & req_ready[i]; result transfer on res_valid & res_ready.
REQ-017 req_ready asserted only in IDLE, or in DONE while res_ready is high; otherwise all zero.
REQ-018 Grant is round-robin: search starts at last_grant+1 and wraps modulo NUM_REQ; req_ready[i] goes high combinationally for the first valid index found.
REQ-019 On request transfer: latch a, b, and tag into operand registers; update last_grant to the tag; go to CALC.
REQ-020 IDLE with no req_valid: remain in IDLE; last_grant unchanged.
REQ-021 CALC lasts exactly one cycle: register the combinational adder output into res_data; go to DONE.
REQ-022 DONE: res_valid=1; res_data and res_tag held stable until the result transfer.
REQ-023 DONE, res_ready=0: remain in DONE; no grant.
REQ-024 DONE, res_ready=1, no req_valid: op_count increments; go to IDLE.
REQ-025 DONE, res_ready=1, any req_valid: complete the result transfer and accept the next request in the same cycle (op_count increments, new operands latched); go to CALC.
REQ-026 Latency: request transfer at cycle t gives res_valid at t+2; sustained throughput is one result per 2 cycles.
REQ-027 op_count wraps from 0xFFFF to 0x0000 without saturation.
REQ-028 req_valid deasserted by a non-granted requester has no effect; a granted request is never dropped.
REQ-029 Adder arithmetic (denormal handling, normalisation, truncation) is inherited unchanged from the shared adder.

Reset
REQ-030 On rst_n low, immediately: state=IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), operand regs=0, res_data=0, res_tag=0, op_count=0.
REQ-031 During reset: res_valid=0, busy=0, req_ready=0.
REQ-032 Reset asserted in CALC or DONE discards the in-flight operation; no result is emitted after release.
REQ-033 Reset is released synchronously to clk by the system; the block needs no internal synchroniser.

Structure
REQ-034 Shared package or include holds the state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and FP_W=32.
REQ-035 The block instantiates exactly one existing adder sub-module as the shared datapath, fed from the operand registers.
REQ-036 Round-robin selection is a combinational function inside the block; no extra sub-module.

Verification
REQ-037 Single op: req_valid=0001, a=0x3F800000, b=0x40000000 -> res_data=0x40400000, res_tag=0, res_valid two cycles after the grant.
REQ-038 Fairness: all four valid continuously, res_ready=1 -> grant order 0,1,2,3,0, one grant every 2 cycles, op_count=5 after 5 results.
REQ-039 Backpressure: res_ready=0 for 10 cycles in DONE -> res_data/res_tag stable, req_ready=0 throughout, busy=1.
REQ-040 Back-to-back: res_ready=1 with req_valid=0100 in DONE -> same-cycle result and request transfers, next res_tag=2.
REQ-041 Reset mid-op: rst_n low during CALC -> res_valid=0, op_count=0 immediately; no stale result after release.
REQ-042 Wrap: preload 0xFFFF completions -> one more result gives op_count=0x0000.

Source files
------------

// File: rtl/fp_add_arbiter_pkg.sv
// fp_add_arbiter_pkg
// Shared definitions for the FP adder arbiter slice.
// Contents: the arbiter state encoding, the float width and the quiet-NaN
// pattern that the shared adder returns for invalid operations.
package fp_add_arbiter_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_add_arbiter_fp_add.sv
// fp_add_arbiter_fp_add
// Shared combinational IEEE-754 single-precision adder.
// Ports:
//   a, b : operands
//   sum  : a + b
// Arithmetic: denormal inputs take exponent 1 with no hidden bit. Results
// are truncated, not rounded. Results that underflow come out denormal.
// Results that overflow come out as infinity. Any NaN input, or inf - inf,
// gives a quiet NaN.
module fp_add_arbiter_fp_add
  import fp_add_arbiter_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum
);

  logic        a_s, b_s, big_s;
  logic [7:0]  a_e, b_e, a_ee, b_ee, big_e, small_e, diff;
  logic [22:0] a_f, b_f, frac;
  // Mantissa layout: [24] carry headroom, [23] hidden bit, [22:0] fraction
  logic [24:0] a_m, b_m, big_m, small_m, small_al, mag;
  logic [23:0] norm;
  logic [4:0]  lz, shift;
  logic        found;
  logic [9:0]  res_e;

  always_comb begin
    a_s  = a[31];
    a_e  = a[30:23];
    a_f  = a[22:0];
    b_s  = b[31];
    b_e  = b[30:23];
    b_f  = b[22:0];
    a_ee = (a_e == 8'd0) ? 8'd1 : a_e;
    b_ee = (b_e == 8'd0) ? 8'd1 : b_e;
    a_m  = {1'b0, (a_e != 8'd0), a_f};
    b_m  = {1'b0, (b_e != 8'd0), b_f};

    // The operand with the larger magnitude sets the result sign and the base exponent.
    if (a[30:0] >= b[30:0]) begin
      big_s   = a_s;
      big_e   = a_ee;
      big_m   = a_m;
      small_e = b_ee;
      small_m = b_m;
    end else begin
      big_s   = b_s;
      big_e   = b_ee;
      big_m   = b_m;
      small_e = a_ee;
      small_m = a_m;
    end

    diff     = big_e - small_e;
    small_al = (diff > 8'd24) ? 25'd0 : (small_m >> diff);
    mag      = (a_s == b_s) ? (big_m + small_al) : (big_m - small_al);

    lz    = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found) begin
        if (mag[i]) found = 1'b1;
        else        lz    = lz + 5'd1;
      end
    end

    shift = 5'd0;
    norm  = 24'd0;
    res_e = 10'd0;
    frac  = 23'd0;
    if (mag[24]) begin
      res_e = {2'b00, big_e} + 10'd1;
      frac  = mag[23:1];
    end else begin
      // Left shift is capped so the exponent stops at 1.
      // Anything still unnormalised after that becomes a denormal.
      if ({3'b000, lz} <= (big_e - 8'd1)) shift = lz;
      else                                 shift = 5'(big_e - 8'd1);
      norm  = mag[23:0] << shift;
      res_e = norm[23] ? ({2'b00, big_e} - {5'b00000, shift}) : 10'd0;
      frac  = norm[22:0];
    end

    sum = '0;
    if (a_e == 8'hFF || b_e == 8'hFF) begin
      if ((a_e == 8'hFF && a_f != 23'd0) || (b_e == 8'hFF && b_f != 23'd0))
        sum = QNAN;
      else if (a_e == 8'hFF && b_e == 8'hFF && a_s != b_s)
        sum = QNAN;
      else
        sum = (a_e == 8'hFF) ? a : b;
    end else if (mag == 25'd0) begin
      sum = {a_s & b_s, 31'd0};
    end else if (res_e >= 10'd255) begin
      sum = {big_s, 8'hFF, 23'd0};
    end else begin
      sum = {big_s, res_e[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// NUM_REQ requesters share one FP adder through a round-robin arbiter.
// Ports:
//   clk, rst_n            : clock; asynchronous active-low reset
//   req_valid / req_ready : per-requester request handshake (ready is one-hot or zero)
//   req_a, req_b          : packed operands; requester i uses bits [32i+31:32i]
//   res_valid / res_ready : result handshake
//   res_data, res_tag     : sum and index of the requester that issued it
//   busy                  : high whenever the FSM is not IDLE
//   op_count              : count of completed result handshakes; wraps at 16 bits
module fp_add_arbiter
  import fp_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [FP_W-1:0]         res_data,
  output logic [TAG_W-1:0]        res_tag,
  output logic                    busy,
  output logic [15:0]             op_count
);

  state_t           state;
  logic [TAG_W-1:0] last_grant;
  logic [TAG_W-1:0] op_tag;
  logic [FP_W-1:0]  op_a, op_b, add_sum;
  logic [TAG_W:0]   pick;
  logic             grant_found;
  logic [TAG_W-1:0] grant_idx;
  logic             can_accept;
  logic             req_xfer;

  // Return value is {found, index}.
  // The search starts one past the last winner and wraps, so every active
  // requester is served within NUM_REQ grants.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [TAG_W-1:0]   last);
    int idx;
    rr_pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!rr_pick[TAG_W] && valid[idx]) rr_pick = {1'b1, TAG_W'(idx)};
    end
  endfunction

  assign pick        = rr_pick(req_valid, last_grant);
  assign grant_found = pick[TAG_W];
  assign grant_idx   = pick[TAG_W-1:0];

  // In DONE, a new request may be accepted only in the cycle the current result leaves.
  assign can_accept = (state == IDLE) || (state == DONE && res_ready);

  // Gating with rst_n keeps ready low for the whole reset, even though the state already reads IDLE.
  always_comb begin
    req_ready = '0;
    if (rst_n && can_accept && grant_found) req_ready[grant_idx] = 1'b1;
  end

  assign req_xfer  = |(req_valid & req_ready);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  fp_add_arbiter_fp_add u_fp_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= TAG_W'(NUM_REQ - 1);
      op_a       <= '0;
      op_b       <= '0;
      op_tag     <= '0;
      res_data   <= '0;
      res_tag    <= '0;
      op_count   <= '0;
    end else begin
      // A request transfer can occur only in IDLE or in DONE-with-res_ready.
      // Both cases latch the operands the same way.
      if (req_xfer) begin
        op_a       <= req_a[FP_W*int'(grant_idx) +: FP_W];
        op_b       <= req_b[FP_W*int'(grant_idx) +: FP_W];
        op_tag     <= grant_idx;
        last_grant <= grant_idx;
      end
      case (state)
        IDLE: begin
          if (req_xfer) state <= CALC;
        end
        CALC: begin
          res_data <= add_sum;
          res_tag  <= op_tag;
          state    <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            op_count <= op_count + 16'd1;
            state    <= req_xfer ? CALC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
